// File: rtl/sweep_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and, when
// SWEEP_GRAY_EN is defined, the Gray-code helper used to order the sweep.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;

  localparam int MAX_N_IN = 6;

`ifdef SWEEP_GRAY_EN
  function automatic logic [MAX_N_IN-1:0] gray(input logic [MAX_N_IN-1:0] i);
    return i ^ (i >> 1);
  endfunction
`endif

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the sweeper and the SOP/POS pair it drives.
// The master modport is the sweeper side; the slave modport is the DUT/host side.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      vec_out;
  logic                 sop_in;
  logic                 pos_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   truth_table;
  logic [N_IN:0]        mismatch_cnt;
  logic [N_IN-1:0]      first_bad_vec;
  logic                 first_bad_valid;

  modport master (
    input  start, sop_in, pos_in,
    output vec_out, busy, done, truth_table, mismatch_cnt, first_bad_vec, first_bad_valid
  );

  modport slave (
    output start, sop_in, pos_in,
    input  vec_out, busy, done, truth_table, mismatch_cnt, first_bad_vec, first_bad_valid
  );
endinterface

// File: rtl/sweep_scoreboard.sv
// Result capture for one sweep: observed truth table, SOP/POS disagreement
// count (saturating) and the first disagreeing vector.
module sweep_scoreboard #(
  parameter int N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [N_IN-1:0]      vec,
  input  logic                 sop,
  input  logic                 pos,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_bad_vec,
  output logic                 first_bad_valid
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN:0] CNT_MAX = (N_IN+1)'(NV);

  logic [NV-1:0]   tt_reg;
  logic [NV-1:0]   hit;
  logic [N_IN:0]   cnt_reg;
  logic [N_IN-1:0] fbv_reg;
  logic            fvalid_reg;
  logic            mismatch_seen;

  for (genvar gi = 0; gi < NV; gi++) begin : g_hit
    assign hit[gi] = sample && (vec == N_IN'(gi));
  end

  // Any unknown on either input lands in the default arm and counts as a mismatch.
  always_comb begin
    mismatch_seen = 1'b1;
    case ({sop, pos})
      2'b00, 2'b11: mismatch_seen = 1'b0;
      default:      mismatch_seen = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_reg     <= '0;
      cnt_reg    <= '0;
      fbv_reg    <= '0;
      fvalid_reg <= 1'b0;
    end else if (clear) begin
      tt_reg     <= '0;
      cnt_reg    <= '0;
      fbv_reg    <= '0;
      fvalid_reg <= 1'b0;
    end else begin
      tt_reg <= (tt_reg & ~hit) | ({NV{sop}} & hit);
      if (sample && mismatch_seen) begin
        if (cnt_reg != CNT_MAX)
          cnt_reg <= cnt_reg + 1'b1;
        if (!fvalid_reg) begin
          fbv_reg    <= vec;
          fvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign truth_table     = tt_reg;
  assign mismatch_cnt    = cnt_reg;
  assign first_bad_vec   = fbv_reg;
  assign first_bad_valid = fvalid_reg;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every N_IN-bit vector for HOLD cycles and samples the SOP/POS pair.
// Define SWEEP_GRAY_EN to walk the vectors in Gray-code order.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  truth_table_sweeper_if.master    bus
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  sweep_state_t    state_reg;
  logic [N_IN-1:0] idx_reg;
  logic [N_IN-1:0] vec_reg;
  logic [HW-1:0]   hold_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [N_IN-1:0] idx_next;
  logic [N_IN-1:0] seq_next;
  logic            sample;
  logic            clear;

  assign idx_next = idx_reg + 1'b1;

`ifdef SWEEP_GRAY_EN
  assign seq_next = N_IN'(gray(MAX_N_IN'(idx_next)));
`else
  assign seq_next = idx_next;
`endif

  assign sample = (state_reg == RUN) && (hold_reg == HOLD_LAST);
  assign clear  = bus.start && (state_reg != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      vec_reg   <= '0;
      hold_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg <= RUN;
            idx_reg   <= '0;
            vec_reg   <= '0;
            hold_reg  <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (hold_reg == HOLD_LAST) begin
            hold_reg <= '0;
            // Last vector stays on vec_out so the results remain consistent with it.
            if (idx_reg == IDX_LAST) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_next;
              vec_reg <= seq_next;
            end
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  sweep_scoreboard #(.N_IN(N_IN)) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .sample          (sample),
    .vec             (vec_reg),
    .sop             (bus.sop_in),
    .pos             (bus.pos_in),
    .truth_table     (bus.truth_table),
    .mismatch_cnt    (bus.mismatch_cnt),
    .first_bad_vec   (bus.first_bad_vec),
    .first_bad_valid (bus.first_bad_valid)
  );

  assign bus.vec_out = vec_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized scoreboard bench: two sweepers (N_IN=3/HOLD=1 and N_IN=4/HOLD=3)
// driven by table-defined SOP/POS functions, checked against a sweep model.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tt;
    int          cnt;
    int          fbv;
    logic        fvalid;
  } exp_t;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic [7:0]  sop_tt_a, pos_tt_a;
  logic [15:0] sop_tt_b, pos_tt_b;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  truth_table_sweeper_if #(.N_IN(3)) a_if ();
  truth_table_sweeper_if #(.N_IN(4)) b_if ();

  assign a_if.start  = start_a;
  assign a_if.sop_in = sop_tt_a[a_if.vec_out];
  assign a_if.pos_in = pos_tt_a[a_if.vec_out];
  assign b_if.start  = start_b;
  assign b_if.sop_in = sop_tt_b[b_if.vec_out];
  assign b_if.pos_in = pos_tt_b[b_if.vec_out];

  truth_table_sweeper #(.N_IN(3), .HOLD(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  truth_table_sweeper #(.N_IN(4), .HOLD(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sweep position i -> vector value.
  function automatic int seq_of(input int i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  function automatic exp_t model(input int n, input logic [15:0] s, input logic [15:0] p);
    exp_t e;
    e.tt = '0; e.cnt = 0; e.fbv = 0; e.fvalid = 1'b0;
    for (int i = 0; i < (1 << n); i++) begin
      int v;
      v = seq_of(i);
      e.tt[v] = s[v];
      if (s[v] != p[v]) begin
        e.cnt++;
        if (!e.fvalid) begin
          e.fvalid = 1'b1;
          e.fbv = v;
        end
      end
    end
    return e;
  endfunction

  function automatic logic dbusy(input int id);
    return (id == 0) ? a_if.busy : b_if.busy;
  endfunction
  function automatic logic ddone(input int id);
    return (id == 0) ? a_if.done : b_if.done;
  endfunction
  function automatic logic [15:0] dtt(input int id);
    return (id == 0) ? {8'h00, a_if.truth_table} : b_if.truth_table;
  endfunction
  function automatic logic [4:0] dcnt(input int id);
    return (id == 0) ? {1'b0, a_if.mismatch_cnt} : b_if.mismatch_cnt;
  endfunction
  function automatic logic [3:0] dvec(input int id);
    return (id == 0) ? {1'b0, a_if.vec_out} : b_if.vec_out;
  endfunction
  function automatic logic [3:0] dfbv(input int id);
    return (id == 0) ? {1'b0, a_if.first_bad_vec} : b_if.first_bad_vec;
  endfunction
  function automatic logic dfvalid(input int id);
    return (id == 0) ? a_if.first_bad_valid : b_if.first_bad_valid;
  endfunction

  task automatic chk_zero(input int id, input string tag);
    chk({tag, "_vec"},    32'(dvec(id)),    0);
    chk({tag, "_busy"},   32'(dbusy(id)),   0);
    chk({tag, "_done"},   32'(ddone(id)),   0);
    chk({tag, "_tt"},     32'(dtt(id)),     0);
    chk({tag, "_cnt"},    32'(dcnt(id)),    0);
    chk({tag, "_fbv"},    32'(dfbv(id)),    0);
    chk({tag, "_fvalid"}, 32'(dfvalid(id)), 0);
  endtask

  // Monitor state, per instance.
  logic prev_busy[2], prev_done[2];
  int   prev_vec[2], run_len[2], step[2], busy_cyc[2];

  task automatic mon(input int id, input int nv, input int hold);
    logic b, d;
    int v;
    exp_t e;
    b = dbusy(id);
    d = ddone(id);
    v = int'(dvec(id));
    if (rst) begin
      prev_busy[id] = 1'b0; prev_done[id] = 1'b0;
      run_len[id] = 0; step[id] = 0; busy_cyc[id] = 0;
      return;
    end
    if (b) begin
      if (!prev_busy[id]) begin
        chk($sformatf("dut%0d_first_vec", id), 32'(v), 0);
        busy_cyc[id] = 0; run_len[id] = 1; step[id] = 0;
      end else if (v == prev_vec[id]) begin
        run_len[id]++;
      end else begin
        chk($sformatf("dut%0d_hold_len", id), 32'(run_len[id]), 32'(hold));
        step[id]++;
        chk($sformatf("dut%0d_vec_order", id), 32'(v), 32'(seq_of(step[id])));
        run_len[id] = 1;
      end
      busy_cyc[id]++;
    end
    if (d && !prev_done[id]) begin
      chk($sformatf("dut%0d_hold_last", id), 32'(run_len[id]), 32'(hold));
      chk($sformatf("dut%0d_steps", id), 32'(step[id]), 32'(nv - 1));
      chk($sformatf("dut%0d_latency", id), 32'(busy_cyc[id]), 32'(nv * hold));
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        chk($sformatf("dut%0d_unexpected_done", id), 1, 0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        $display("[TB] dut%0d sweep: tt=%h cnt=%0d first=%0d valid=%0b", id,
                 dtt(id), dcnt(id), dfbv(id), dfvalid(id));
        chk($sformatf("dut%0d_tt", id),     32'(dtt(id)),     32'(e.tt));
        chk($sformatf("dut%0d_cnt", id),    32'(dcnt(id)),    32'(e.cnt));
        chk($sformatf("dut%0d_fbv", id),    32'(dfbv(id)),    32'(e.fbv));
        chk($sformatf("dut%0d_fvalid", id), 32'(dfvalid(id)), 32'(e.fvalid));
      end
    end
    prev_busy[id] = b;
    prev_done[id] = d;
    prev_vec[id]  = v;
  endtask

  always @(negedge clk) mon(0, 8, 1);
  always @(negedge clk) mon(1, 16, 3);

  task automatic set_start(input int id, input logic val);
    if (id == 0) start_a = val; else start_b = val;
  endtask

  // mode: 0 plain sweep, 1 extra start pulse at idx=2, 2 reset at idx=5
  task automatic run(input int id, input logic [15:0] s, input logic [15:0] p, input int mode);
    int n, hold;
    bit seen;
    n    = (id == 0) ? 3 : 4;
    hold = (id == 0) ? 1 : 3;
    if (id == 0) begin sop_tt_a = s[7:0]; pos_tt_a = p[7:0]; end
    else         begin sop_tt_b = s;      pos_tt_b = p;      end
    if (id == 0) q0.push_back(model(n, s, p)); else q1.push_back(model(n, s, p));
    @(negedge clk); set_start(id, 1'b1);
    @(posedge clk); #1; set_start(id, 1'b0);
    chk($sformatf("dut%0d_start_busy", id),   32'(dbusy(id)),   1);
    chk($sformatf("dut%0d_start_done", id),   32'(ddone(id)),   0);
    chk($sformatf("dut%0d_start_tt", id),     32'(dtt(id)),     0);
    chk($sformatf("dut%0d_start_cnt", id),    32'(dcnt(id)),    0);
    chk($sformatf("dut%0d_start_fvalid", id), 32'(dfvalid(id)), 0);
    if (mode == 1) begin
      repeat (2 * hold) @(posedge clk);
      @(negedge clk); set_start(id, 1'b1);
      @(negedge clk); set_start(id, 1'b0);
    end else if (mode == 2) begin
      repeat (5 * hold) @(posedge clk);
      @(negedge clk);
      chk($sformatf("dut%0d_pre_rst_vec", id), 32'(dvec(id)), 32'(seq_of(5)));
      rst = 1'b1;
      #1;
      chk_zero(id, $sformatf("dut%0d_midrst", id));
      if (id == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      @(posedge clk); #1; rst = 1'b0;
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = ddone(id);
    end
    chk($sformatf("dut%0d_done_seen", id), 32'(seen), 1);
  endtask

  task automatic rand_run(input int id, input int mode);
    logic [15:0] s, p;
    s = 16'($urandom);
    case ($urandom_range(0, 2))
      0:       p = s;
      1:       p = ~s;
      default: p = 16'($urandom);
    endcase
    run(id, s, p, mode);
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    sop_tt_a = '0; pos_tt_a = '0; sop_tt_b = '0; pos_tt_b = '0;
    #1 rst = 1'b1;
    #2;
    chk_zero(0, "dut0_rst");
    chk_zero(1, "dut1_rst");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run(0, 16'h0067, 16'h0067, 0);
    run(0, 16'h0067, 16'h0000, 0);
    run(0, 16'h00A5, 16'h005A, 0);
    rand_run(0, 1);
    rand_run(0, 2);
    rand_run(0, 0);
    for (int k = 0; k < 5; k++) rand_run(0, 0);

    run(1, 16'hAAAA, 16'hAAAA, 0);
    run(1, 16'h1234, 16'hEDCB, 0);
    rand_run(1, 1);
    rand_run(1, 2);
    for (int k = 0; k < 4; k++) rand_run(1, 0);

    repeat (5) @(negedge clk);
    chk("queues_empty", 32'(q0.size() + q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus and response stage for the combinational SOP/POS function blocks. It drives every input vector of an N_IN-input function in turn and captures two function outputs: the minterm (SOP) form and the maxterm (POS) form of the same function. It builds the observed truth table, counts SOP/POS disagreements and records the first disagreeing vector. It is the driving and checking stage placed around each minterm/maxterm pair.

Parameters:
- N_IN, 4, number of function inputs (vec_out width); legal range 1..6.
- HOLD, 2, cycles each vector is held before sampling; legal range >=1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; one clock domain, asynchronous and active-high.
- start  in  1  pulse or level; accepted only in IDLE or DONE.
- vec_out  out  N_IN  vector driven to both DUTs; MSB = a, LSB = last input.
- sop_in  in  1  minterm-form DUT output (combinational from vec_out).
- pos_in  in  1  maxterm-form DUT output (combinational from vec_out).
- busy  out  1  high while sweeping.
- done  out  1  high from sweep end until the next accepted start or reset.
- truth_table  out  2**N_IN  bit k = sop_in sampled while vector value k was driven.
- mismatch_cnt  out  N_IN+1  count of vectors with sop_in != pos_in; maximum 2**N_IN, never wraps.
- first_bad_vec  out  N_IN  vector value of the first mismatch.
- first_bad_valid  out  1  high once first_bad_vec is loaded.

Behaviour:
- Reset (async, any state, including mid-sweep): state IDLE, vec_out=0, busy=0, done=0, truth_table=0, mismatch_cnt=0, first_bad_vec=0, first_bad_valid=0, idx=0, hold_cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE --start--> RUN.
- RUN --last sample--> DONE.
- DONE --start--> RUN.
- No other transitions. start in RUN is ignored.
- Start accepted at edge t:
  - Clears truth_table, mismatch_cnt, first_bad_*, idx and hold_cnt.
  - busy=1 and vec_out=seq(0) visible after edge t.
  - done drops at the same edge.
- RUN:
  - vec_out = seq(idx), held for HOLD cycles; hold_cnt counts 0..HOLD-1.
  - At the edge where hold_cnt==HOLD-1 (sample edge), register sop_in/pos_in:
    - truth_table[seq(idx)] <= sop_in.
    - If sop_in != pos_in: mismatch_cnt += 1.
    - If this is the first mismatch (first_bad_valid==0): first_bad_vec <= seq(idx) and first_bad_valid <= 1.
  - Then idx += 1 and hold_cnt = 0.
  - On the sample edge with idx == 2**N_IN-1: go to DONE, busy=0, done=1. vec_out keeps the last vector.
- Latency: done is visible after edge t + 2**N_IN*HOLD.
- Results hold stable in DONE and are cleared only by an accepted start or by reset.
- seq(i) = i (binary order) unless SWEEP_GRAY_EN is defined.
- Unknown (X) DUT outputs are compared as != and count as a mismatch; the bench must tie DUTs to known values.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined: seq(i) = i ^ (i >> 1), so the sweep walks the vectors in Gray-code order and only one input bit toggles per vector.
- truth_table and first_bad_vec are still indexed by the actual vector value, so final results are identical to binary order.
- Not defined: plain binary count order. No Gray logic is present.

Decomposition:
- Package sweep_pkg holds:
  - typedef enum sweep_state_t {IDLE, RUN, DONE}.
  - Helper function gray(i), guarded by SWEEP_GRAY_EN.
- One sub-module, sweep_scoreboard, owns truth_table, mismatch_cnt and first_bad_*. Its inputs are a sample strobe, the vector, sop_in and pos_in, and a clear.
- The FSM, idx and hold_cnt stay in truth_table_sweeper.

Test Plan:
- N_IN=3, HOLD=1; sop_in = !a!b+!bc+b!c; pos_in = (!a+b+c)(!b+!c); start at edge t -> done after edge t+8, truth_table=8'h67, mismatch_cnt=0, first_bad_valid=0.
- Same setup with pos_in tied 0 -> mismatch_cnt=5, first_bad_vec=3'b000, first_bad_valid=1, truth_table=8'h67.
- N_IN=4, HOLD=3, sop_in=pos_in=d -> done after edge t+48; each vector held exactly 3 cycles; truth_table=16'hAAAA.
- Assert rst for 1 cycle when idx=5 -> all outputs are 0 immediately, without waiting for a clock edge. After release, start runs a full sweep from vector 0.
- Pulse start during RUN at idx=2 -> ignored; done timing unchanged. Start in DONE -> results cleared and sweep restarts; done=0 after that edge.
- With SWEEP_GRAY_EN: vec_out order 0,1,3,2,6,7,5,4 (N_IN=3) -> exactly one bit change per vector; truth_table equals the binary-order result.
